iterative_divider: RTL and testbench
====================================

// Module: iterative_divider
// PURPOSE
//  - Multi-cycle RV64M divide unit: DIV, DIVU, REM, REMU.
//  - Restoring algorithm; each step is one XLEN+1-bit trial subtraction of the divisor from the partial remainder.
//  - The subtractor borrow decides the quotient bit and whether to restore.
//  - Sits in EX beside the ALU; the pipeline stalls on busy and captures result on done.
// PARAMETERS
//  - XLEN  64  operand/result width
//    (step counter width = $clog2(XLEN)+1, localparam)
// PORTS
//  - clk          in   1     single clock, rising edge
//  - rst          in   1     synchronous, active-high reset
//  - start        in   1     request; sampled only when busy=0
//  - op           in   2     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  - a            in   XLEN  dividend
//  - b            in   XLEN  divisor
//  - busy         out  1     high in CALC and FIXUP
//  - done         out  1     one-cycle pulse; result valid
//  - result       out  XLEN  quotient or remainder per op; held until next done
//  - div_by_zero  out  1     registered with result; b==0 on the accepted op
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - state=IDLE; busy=0, done=0, result=0, div_by_zero=0; counter and internal regs cleared.
//  - States: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
//  - IDLE/DONE + start=1: latch op.
//    - Latch |a| and |b| when op is signed (op[0]=0), raw a and b otherwise.
//    - Record sign flags; clear remainder; counter=0; go to CALC.
//  - Start is accepted in DONE; done still pulses that cycle.
//  - Start while busy=1 is ignored; a/b/op need only be stable in the start cycle.
//  - CALC, one step per cycle, XLEN cycles:
//    - rem' = {rem[XLEN-1:0], dvd[XLEN-1]}; trial = rem' - dvs (XLEN+1 bits).
//    - borrow=0: rem <= trial, q bit 1. Borrow=1: rem <= rem', q bit 0.
//    - Counter == XLEN-1 -> FIXUP.
//  - FIXUP, one cycle:
//    - Negate quotient if sign(a)^sign(b) (signed ops); negate remainder if sign(a).
//    - Apply special cases, then register result and div_by_zero.
//  - Special cases (RISC-V spec):
//    - b==0: quotient = all ones, remainder = a, div_by_zero=1.
//    - Signed overflow (a = 0x8000_0000_0000_0000, b = -1): quotient = a, remainder = 0.
//  - DONE: done=1 for exactly one cycle, then IDLE unless start is accepted.
//  - Latency: done is high in the cycle XLEN+2 after start is sampled (66 at default); throughput is one op per XLEN+2 cycles.
//  - All arithmetic is modulo 2^XLEN; signed values are two's complement.
//  - rst mid-operation: abort next edge, reset values above, no done pulse for the aborted op.
// CONFIGURATION
//  - DIV_EARLY_OUT_EN defined:
//    - In the accepting cycle, b==0 or signed overflow goes IDLE -> FIXUP directly.
//    - done is then high 2 cycles after start, with identical results/flags.
//  - Undefined: every op takes the full XLEN+2 cycles; results are identical.
// TESTING
//  - DIVU a=0xA b=0x5 -> result=0x2, div_by_zero=0, done exactly 66 cycles after start, single-cycle pulse.
//  - REMU a=0x5 b=0xA -> 0x5. DIV a=-7 b=2 -> 0xFFFF_FFFF_FFFF_FFFD. REM a=-7 b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
//  - DIVU a=0x1234 b=0 -> 0xFFFF_FFFF_FFFF_FFFF, div_by_zero=1. REM a=0x1234 b=0 -> 0x1234.
//    Done at cycle 2 with DIV_EARLY_OUT_EN, cycle 66 without.
//  - DIV a=0x8000_0000_0000_0000 b=0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000; REM same operands -> 0x0.
//  - Start DIVU 100/7, pulse start with 50/5 at cycle 10 -> ignored; result=14 at cycle 66.
//    Start again in the DONE cycle -> accepted; result=10 at 66 cycles later.
//  - Start DIVU 0xFFFF_FFFF_FFFF_FFFF/3, assert rst at cycle 30 -> next cycle busy=0, result=0; no done ever pulses.

Source files
------------

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for RV64M DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterative phase.
module iterative_divider #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            div_by_zero
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] dvd_q, dvd_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] a_q, a_d;
   logic            neg_q_q, neg_q_d;
   logic            neg_r_q, neg_r_d;
   logic            is_rem_q, is_rem_d;
   logic            bz_q, bz_d;
   logic            ovf_q, ovf_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            dbz_q, dbz_d;

   logic            is_signed_in;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] abs_a, abs_b;
   logic            b_zero_in, ovf_in;
   logic [XLEN:0]   rem_shift, trial;
   logic            borrow;
   logic [XLEN-1:0] q_fix, r_fix, q_sel, r_sel;

   assign is_signed_in = ~op[0];
   assign a_neg        = is_signed_in & a[XLEN-1];
   assign b_neg        = is_signed_in & b[XLEN-1];
   assign abs_a        = a_neg ? -a : a;
   assign abs_b        = b_neg ? -b : b;
   assign b_zero_in    = (b == '0);
   assign ovf_in       = is_signed_in & (a == MIN_NEG) & (b == '1);

   // One restoring step: the borrow of the trial subtraction selects restore vs. keep.
   assign rem_shift = {rem_q, dvd_q[XLEN-1]};
   assign trial     = rem_shift - {1'b0, dvs_q};
   assign borrow    = trial[XLEN];

   assign q_fix = neg_q_q ? -dvd_q : dvd_q;
   assign r_fix = neg_r_q ? -rem_q : rem_q;

   // Special cases override the iterated values, which may never have been computed on early-out.
   always_comb begin
      q_sel = q_fix;
      r_sel = r_fix;
      if (bz_q) begin
         q_sel = '1;
         r_sel = a_q;
      end else if (ovf_q) begin
         q_sel = a_q;
         r_sel = '0;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      a_d      = a_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      is_rem_d = is_rem_q;
      bz_d     = bz_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      dbz_d    = dbz_q;
      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE) state_d = IDLE;
            if (start) begin
               dvd_d    = abs_a;
               dvs_d    = abs_b;
               rem_d    = '0;
               a_d      = a;
               cnt_d    = '0;
               neg_q_d  = a_neg ^ b_neg;
               neg_r_d  = a_neg;
               is_rem_d = op[1];
               bz_d     = b_zero_in;
               ovf_d    = ovf_in;
`ifdef DIV_EARLY_OUT_EN
               state_d  = (b_zero_in | ovf_in) ? FIXUP : CALC;
`else
               state_d  = CALC;
`endif
            end
         end
         CALC: begin
            rem_d = borrow ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
            dvd_d = {dvd_q[XLEN-2:0], ~borrow};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) state_d = FIXUP;
         end
         FIXUP: begin
            result_d = is_rem_q ? r_sel : q_sel;
            dbz_d    = bz_q;
            state_d  = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         a_q      <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         is_rem_q <= 1'b0;
         bz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         a_q      <= a_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         is_rem_q <= is_rem_d;
         bz_q     <= bz_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = (state_q == CALC) || (state_q == FIXUP);
   assign done        = (state_q == DONE);
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed vectors, random ops, back-to-back, reset abort.
module tb_iterative_divider;

   localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ALL1    = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [1:0]  op;
   logic [63:0] a, b;
   logic        busy, done, div_by_zero;
   logic [63:0] result;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] res;
      logic        dz;
      int          due;
   } exp_t;
   exp_t sb[$];

   iterative_divider #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: RISC-V M-extension semantics
   function automatic logic [64:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
      logic signed [63:0] sx, sy;
      logic [63:0] q, r;
      sx = x; sy = y;
      if (y == 64'd0) begin
         q = ALL1; r = x;
      end else if (!o[0] && x == MIN_NEG && y == ALL1) begin
         q = MIN_NEG; r = 64'd0;
      end else if (!o[0]) begin
         q = sx / sy; r = sx % sy;
      end else begin
         q = x / y; r = x % y;
      end
      return {(y == 64'd0), (o[1] ? r : q)};
   endfunction

   function automatic int latency(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
`ifdef DIV_EARLY_OUT_EN
      if (y == 64'd0 || (!o[0] && x == MIN_NEG && y == ALL1)) return 2;
`endif
      return 66;
   endfunction

   // Called at a negedge; drives one start cycle and pushes the expectation.
   task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp_res, input logic exp_dz);
      exp_t e;
      e.res = exp_res; e.dz = exp_dz; e.due = cyc + latency(o, x, y);
      sb.push_back(e);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin ok = 1'b1; return; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, div_by_zero, result} !== 67'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%0b done=%0b dz=%0b result=%h, required all zero",
                  busy, done, div_by_zero, result);
      end
   endtask

   task automatic test_vectors;
      logic [1:0]  t_op [10] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11};
      logic [63:0] t_a  [10] = '{64'hA, 64'h5, -64'sd7, -64'sd7, 64'h1234, 64'h1234, MIN_NEG, MIN_NEG, -64'sd9, 64'h7};
      logic [63:0] t_b  [10] = '{64'h5, 64'hA, 64'd2, 64'd2, 64'd0, 64'd0, ALL1, ALL1, 64'd0, 64'd0};
      logic [63:0] t_r  [10] = '{64'h2, 64'h5, 64'hFFFF_FFFF_FFFF_FFFD, ALL1, ALL1, 64'h1234,
                                 MIN_NEG, 64'h0, ALL1, 64'h7};
      logic        t_dz [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      bit ok;
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         issue(t_op[i], t_a[i], t_b[i], t_r[i], t_dz[i]);
         wait_done(ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL vec%0d_timeout: done=0 after 200 cycles, required done pulse", i);
            sb.delete();
            continue;
         end
         e = sb.pop_front();
         checks += 3;
         if (result !== e.res) begin
            errors++;
            $display("FAIL vec%0d_result: got %h, required %h", i, result, e.res);
         end
         if (div_by_zero !== e.dz) begin
            errors++;
            $display("FAIL vec%0d_dz: got %0b, required %0b", i, div_by_zero, e.dz);
         end
         if (cyc !== e.due) begin
            errors++;
            $display("FAIL vec%0d_latency: done at cycle %0d, required %0d", i, cyc, e.due);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL vec%0d_pulse: done=%0b one cycle later, required 0", i, done);
         end
         $display("vec%0d op=%0d a=%h b=%h result=%h dz=%0b", i, t_op[i], t_a[i], t_b[i], e.res, e.dz);
      end
   endtask

   task automatic test_random;
      logic [1:0]  o;
      logic [63:0] x, y;
      logic [64:0] m;
      bit ok;
      exp_t e;
      for (int i = 0; i < 12; i++) begin
         o = 2'($urandom);
         x = {$urandom, $urandom};
         case (i % 3)
            0:       y = {$urandom, $urandom};
            1:       y = 64'($urandom_range(1, 1000));
            default: y = -64'($urandom_range(1, 1000));
         endcase
         m = model(o, x, y);
         issue(o, x, y, m[63:0], m[64]);
         wait_done(ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL rnd%0d_timeout: done=0 after 200 cycles, required done pulse", i);
            sb.delete();
            continue;
         end
         e = sb.pop_front();
         checks += 2;
         if (result !== e.res || div_by_zero !== e.dz) begin
            errors++;
            $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got %h/%0b, required %h/%0b",
                     i, o, x, y, result, div_by_zero, e.res, e.dz);
         end
         if (cyc !== e.due) begin
            errors++;
            $display("FAIL rnd%0d_latency: done at cycle %0d, required %0d", i, cyc, e.due);
         end
         $display("rnd%0d op=%0d a=%h b=%h result=%h", i, o, x, y, e.res);
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      int c0;
      bit ok;
      exp_t e;
      c0 = cyc;
      issue(2'b01, 64'd100, 64'd7, 64'd14, 1'b0);
      while (cyc < c0 + 10) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_busy: busy=%0b at cycle 10, required 1", busy);
      end
      start = 1'b1; op = 2'b01; a = 64'd50; b = 64'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_first_timeout: no done, required done");
         sb.delete();
         return;
      end
      e = sb.pop_front();
      checks += 2;
      if (result !== e.res) begin
         errors++;
         $display("FAIL b2b_first_result: got %0d, required %0d", result, e.res);
      end
      if (cyc !== e.due) begin
         errors++;
         $display("FAIL b2b_first_latency: done at cycle %0d, required %0d", cyc, e.due);
      end
      $display("b2b first DIVU 100/7 result=%0d", result);
      issue(2'b01, 64'd50, 64'd5, 64'd10, 1'b0);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: done=%0b busy=%0b after start in DONE, required 0/1", done, busy);
      end
      wait_done(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_second_timeout: no done, required done");
         sb.delete();
         return;
      end
      e = sb.pop_front();
      checks += 2;
      if (result !== e.res) begin
         errors++;
         $display("FAIL b2b_second_result: got %0d, required %0d", result, e.res);
      end
      if (cyc !== e.due) begin
         errors++;
         $display("FAIL b2b_second_latency: done at cycle %0d, required %0d", cyc, e.due);
      end
      $display("b2b second DIVU 50/5 result=%0d", result);
      @(negedge clk);
   endtask

   task automatic test_reset_abort;
      int  c0;
      bit  seen;
      bit  ok;
      exp_t e;
      // Leave a nonzero result and div_by_zero=1 so the reset clearing is observable.
      issue(2'b11, 64'h55, 64'd0, 64'h55, 1'b1);
      wait_done(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL abort_setup_timeout: no done, required done");
      end else begin
         e = sb.pop_front();
         if (result !== e.res || div_by_zero !== e.dz) begin
            errors++;
            $display("FAIL abort_setup_result: got %h/%0b, required %h/%0b", result, div_by_zero, e.res, e.dz);
         end
      end
      sb.delete();
      @(negedge clk);
      c0 = cyc;
      start = 1'b1; op = 2'b01; a = ALL1; b = 64'd3;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + 30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, div_by_zero, result} !== 67'd0) begin
         errors++;
         $display("FAIL abort_state: busy=%0b done=%0b dz=%0b result=%h, required all zero",
                  busy, done, div_by_zero, result);
      end
      seen = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_no_done: done pulsed after reset, required none");
      end
      $display("abort DIVU all-ones/3 reset at cycle 30 busy=%0b result=%h", busy, result);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
      @(negedge clk);
      test_reset;
      test_vectors;
      test_back_to_back;
      test_random;
      test_reset_abort;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
